// File: rtl/writeback_regfile.sv
// Writeback register file: 32 x 32-bit registers fed by an ALU path and a
// single-outstanding load path, with read bypass, load scoreboard, retire
// counter and a registered write trace.
module writeback_regfile #(
  parameter int unsigned RETIRE_W = 32
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                wb_en_in,
  input  logic [5:0]          wb_rd_sel_in,
  input  logic [31:0]         wb_data_in,
  input  logic                ld_issue_in,
  input  logic [5:0]          ld_rd_sel_in,
  input  logic                ld_valid_in,
  input  logic [31:0]         ld_data_in,
  input  logic [4:0]          rs1_sel,
  input  logic [4:0]          rs2_sel,
  output logic [31:0]         rs1_data,
  output logic [31:0]         rs2_data,
  output logic                rs1_busy,
  output logic                rs2_busy,
  output logic                ld_err,
  output logic [RETIRE_W-1:0] retire_count,
  output logic                trace_wb_valid,
  output logic [4:0]          trace_wb_rd,
  output logic [31:0]         trace_wb_data
);

  typedef enum logic [0:0] {StIdle, StPending} ld_state_e;

  ld_state_e             state_q, state_d;
  logic [4:0]            ld_rd_q, ld_rd_d;
  logic                  ld_err_q, ld_err_d;
  logic [RETIRE_W-1:0]   retire_q, retire_d;
  logic                  trace_valid_q, trace_valid_d;
  logic [4:0]            trace_rd_q, trace_rd_d;
  logic [31:0]           trace_data_q, trace_data_d;
  logic [31:0]           rf_q [32];

  logic                  alu_we;
  logic [4:0]            alu_rd;
  logic                  ld_issue_ok;
  logic                  ld_we;

  // Qualify writes: bit 5 is reserved and x0 is never a real destination.
  assign alu_rd      = wb_rd_sel_in[4:0];
  assign alu_we      = wb_en_in & ~wb_rd_sel_in[5] & (|wb_rd_sel_in[4:0]);
  assign ld_issue_ok = ld_issue_in & ~ld_rd_sel_in[5] & (|ld_rd_sel_in[4:0]);

  // Load tracker state register.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q  <= StIdle;
      ld_rd_q  <= '0;
      ld_err_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      ld_rd_q  <= ld_rd_d;
      ld_err_q <= ld_err_d;
    end
  end

  // Load tracker next state; protocol violations make ld_err sticky.
  always_comb begin
    state_d  = state_q;
    ld_rd_d  = ld_rd_q;
    ld_err_d = ld_err_q;
    unique case (state_q)
      StIdle: begin
        if (ld_valid_in) ld_err_d = 1'b1;
        if (ld_issue_ok) begin
          state_d = StPending;
          ld_rd_d = ld_rd_sel_in[4:0];
        end
      end
      StPending: begin
        if (ld_valid_in) begin
          // Completion and a new issue in the same cycle chain directly.
          if (ld_issue_ok) begin
            ld_rd_d = ld_rd_sel_in[4:0];
          end else begin
            state_d = StIdle;
          end
        end else if (ld_issue_in) begin
          ld_err_d = 1'b1;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  // Load tracker outputs: write enable and operand scoreboard.
  always_comb begin
    ld_we    = (state_q == StPending) & ld_valid_in;
    rs1_busy = (state_q == StPending) & (rs1_sel == ld_rd_q) & ~ld_valid_in;
    rs2_busy = (state_q == StPending) & (rs2_sel == ld_rd_q) & ~ld_valid_in;
  end

  // Register array; the ALU assignment comes last so it wins a same-register collision.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int i = 0; i < 32; i++) rf_q[i] <= '0;
    end else begin
      if (ld_we)  rf_q[ld_rd_q] <= ld_data_in;
      if (alu_we) rf_q[alu_rd]  <= wb_data_in;
    end
  end

  // Retire count and trace next state; both writes count even on a collision.
  always_comb begin
    retire_d      = retire_q + RETIRE_W'(alu_we) + RETIRE_W'(ld_we);
    trace_valid_d = alu_we | ld_we;
    trace_rd_d    = '0;
    trace_data_d  = '0;
    if (alu_we) begin
      trace_rd_d   = alu_rd;
      trace_data_d = wb_data_in;
    end else if (ld_we) begin
      trace_rd_d   = ld_rd_q;
      trace_data_d = ld_data_in;
    end
  end

  // Retire counter and trace registers.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      retire_q      <= '0;
      trace_valid_q <= 1'b0;
      trace_rd_q    <= '0;
      trace_data_q  <= '0;
    end else begin
      retire_q      <= retire_d;
      trace_valid_q <= trace_valid_d;
      trace_rd_q    <= trace_rd_d;
      trace_data_q  <= trace_data_d;
    end
  end

  // Read ports with same-cycle bypass: ALU write, then load write, then array.
  always_comb begin
    rs1_data = rf_q[rs1_sel];
    if (rs1_sel == 5'd0)                     rs1_data = '0;
    else if (alu_we && alu_rd == rs1_sel)    rs1_data = wb_data_in;
    else if (ld_we && ld_rd_q == rs1_sel)    rs1_data = ld_data_in;

    rs2_data = rf_q[rs2_sel];
    if (rs2_sel == 5'd0)                     rs2_data = '0;
    else if (alu_we && alu_rd == rs2_sel)    rs2_data = wb_data_in;
    else if (ld_we && ld_rd_q == rs2_sel)    rs2_data = ld_data_in;
  end

  assign ld_err         = ld_err_q;
  assign retire_count   = retire_q;
  assign trace_wb_valid = trace_valid_q;
  assign trace_wb_rd    = trace_rd_q;
  assign trace_wb_data  = trace_data_q;

endmodule

// File: tb/tb_writeback_regfile.sv
// Directed self-checking bench for writeback_regfile.
module tb_writeback_regfile;

  logic        clk;
  logic        rst_n;
  logic        wb_en_in;
  logic [5:0]  wb_rd_sel_in;
  logic [31:0] wb_data_in;
  logic        ld_issue_in;
  logic [5:0]  ld_rd_sel_in;
  logic        ld_valid_in;
  logic [31:0] ld_data_in;
  logic [4:0]  rs1_sel;
  logic [4:0]  rs2_sel;
  logic [31:0] rs1_data;
  logic [31:0] rs2_data;
  logic        rs1_busy;
  logic        rs2_busy;
  logic        ld_err;
  logic [31:0] retire_count;
  logic        trace_wb_valid;
  logic [4:0]  trace_wb_rd;
  logic [31:0] trace_wb_data;

  int errs;
  int checks;

  writeback_regfile #(.RETIRE_W(32)) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .wb_en_in       (wb_en_in),
    .wb_rd_sel_in   (wb_rd_sel_in),
    .wb_data_in     (wb_data_in),
    .ld_issue_in    (ld_issue_in),
    .ld_rd_sel_in   (ld_rd_sel_in),
    .ld_valid_in    (ld_valid_in),
    .ld_data_in     (ld_data_in),
    .rs1_sel        (rs1_sel),
    .rs2_sel        (rs2_sel),
    .rs1_data       (rs1_data),
    .rs2_data       (rs2_data),
    .rs1_busy       (rs1_busy),
    .rs2_busy       (rs2_busy),
    .ld_err         (ld_err),
    .retire_count   (retire_count),
    .trace_wb_valid (trace_wb_valid),
    .trace_wb_rd    (trace_wb_rd),
    .trace_wb_data  (trace_wb_data)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Advance one clock; inputs change and outputs are sampled 1 time unit after the edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_inputs();
    wb_en_in     = 1'b0;
    wb_rd_sel_in = '0;
    wb_data_in   = '0;
    ld_issue_in  = 1'b0;
    ld_rd_sel_in = '0;
    ld_valid_in  = 1'b0;
    ld_data_in   = '0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    clear_inputs();
    rs1_sel = 5'd5;
    rs2_sel = 5'd0;
    tick();
    tick();
    rst_n = 1'b1;
    #1;
    checks++;
    if (ld_err !== 1'b0) begin
      errs++; $display("FAIL reset_ld_err: got %b want 0", ld_err);
    end
    checks++;
    if (retire_count !== 32'd0) begin
      errs++; $display("FAIL reset_retire: got %0d want 0", retire_count);
    end
    checks++;
    if (trace_wb_valid !== 1'b0 || trace_wb_rd !== 5'd0 || trace_wb_data !== 32'd0) begin
      errs++; $display("FAIL reset_trace: got %b/%0d/%h want 0/0/0",
                       trace_wb_valid, trace_wb_rd, trace_wb_data);
    end
    checks++;
    if (rs1_data !== 32'd0 || rs1_busy !== 1'b0) begin
      errs++; $display("FAIL reset_read: got %h busy %b want 0 busy 0", rs1_data, rs1_busy);
    end
  endtask

  task automatic test_alu_write();
    wb_en_in = 1'b1; wb_rd_sel_in = 6'd5; wb_data_in = 32'hDEADBEEF;
    rs1_sel = 5'd5;
    #1;
    checks++;
    if (rs1_data !== 32'hDEADBEEF) begin
      errs++; $display("FAIL alu_bypass: got %h want deadbeef", rs1_data);
    end
    tick();
    clear_inputs();
    #1;
    checks++;
    if (rs1_data !== 32'hDEADBEEF) begin
      errs++; $display("FAIL alu_array: got %h want deadbeef", rs1_data);
    end
    checks++;
    if (retire_count !== 32'd1) begin
      errs++; $display("FAIL alu_retire: got %0d want 1", retire_count);
    end
    checks++;
    if (trace_wb_valid !== 1'b1 || trace_wb_rd !== 5'd5 || trace_wb_data !== 32'hDEADBEEF) begin
      errs++; $display("FAIL alu_trace: got %b/%0d/%h want 1/5/deadbeef",
                       trace_wb_valid, trace_wb_rd, trace_wb_data);
    end
  endtask

  task automatic test_suppressed();
    wb_en_in = 1'b1; wb_rd_sel_in = 6'd0; wb_data_in = 32'h11111111;
    tick();
    clear_inputs();
    rs1_sel = 5'd0;
    #1;
    checks++;
    if (rs1_data !== 32'd0 || retire_count !== 32'd1 || trace_wb_valid !== 1'b0) begin
      errs++; $display("FAIL x0_write: got data %h retire %0d tv %b want 0 1 0",
                       rs1_data, retire_count, trace_wb_valid);
    end
    wb_en_in = 1'b1; wb_rd_sel_in = 6'h25; wb_data_in = 32'h22222222;
    rs1_sel = 5'd5;
    #1;
    checks++;
    if (rs1_data !== 32'hDEADBEEF) begin
      errs++; $display("FAIL rsvd_bypass: got %h want deadbeef", rs1_data);
    end
    tick();
    clear_inputs();
    #1;
    checks++;
    if (rs1_data !== 32'hDEADBEEF || retire_count !== 32'd1 || trace_wb_valid !== 1'b0) begin
      errs++; $display("FAIL rsvd_write: got data %h retire %0d tv %b want deadbeef 1 0",
                       rs1_data, retire_count, trace_wb_valid);
    end
  endtask

  task automatic test_load();
    ld_issue_in = 1'b1; ld_rd_sel_in = 6'd7;
    tick();
    clear_inputs();
    rs1_sel = 5'd7; rs2_sel = 5'd5;
    #1;
    checks++;
    if (rs1_busy !== 1'b1 || rs2_busy !== 1'b0) begin
      errs++; $display("FAIL load_busy: got %b/%b want 1/0", rs1_busy, rs2_busy);
    end
    ld_valid_in = 1'b1; ld_data_in = 32'h00001234;
    #1;
    checks++;
    if (rs1_busy !== 1'b0 || rs1_data !== 32'h00001234) begin
      errs++; $display("FAIL load_bypass: got busy %b data %h want 0 1234", rs1_busy, rs1_data);
    end
    tick();
    clear_inputs();
    #1;
    checks++;
    if (rs1_data !== 32'h00001234 || retire_count !== 32'd2) begin
      errs++; $display("FAIL load_array: got %h retire %0d want 1234 2", rs1_data, retire_count);
    end
    checks++;
    if (trace_wb_valid !== 1'b1 || trace_wb_rd !== 5'd7 || trace_wb_data !== 32'h00001234) begin
      errs++; $display("FAIL load_trace: got %b/%0d/%h want 1/7/1234",
                       trace_wb_valid, trace_wb_rd, trace_wb_data);
    end
  endtask

  task automatic test_collision();
    ld_issue_in = 1'b1; ld_rd_sel_in = 6'd9;
    tick();
    clear_inputs();
    ld_valid_in = 1'b1; ld_data_in = 32'h00005555;
    wb_en_in = 1'b1; wb_rd_sel_in = 6'd9; wb_data_in = 32'h000000AA;
    rs1_sel = 5'd9;
    #1;
    checks++;
    if (rs1_data !== 32'h000000AA) begin
      errs++; $display("FAIL coll_bypass: got %h want aa", rs1_data);
    end
    tick();
    clear_inputs();
    #1;
    checks++;
    if (rs1_data !== 32'h000000AA || retire_count !== 32'd4 || rs1_busy !== 1'b0) begin
      errs++; $display("FAIL coll_write: got %h retire %0d busy %b want aa 4 0",
                       rs1_data, retire_count, rs1_busy);
    end
    checks++;
    if (trace_wb_valid !== 1'b1 || trace_wb_rd !== 5'd9 || trace_wb_data !== 32'h000000AA) begin
      errs++; $display("FAIL coll_trace: got %b/%0d/%h want 1/9/aa",
                       trace_wb_valid, trace_wb_rd, trace_wb_data);
    end
  endtask

  task automatic test_dual_write();
    ld_issue_in = 1'b1; ld_rd_sel_in = 6'd10;
    tick();
    clear_inputs();
    ld_valid_in = 1'b1; ld_data_in = 32'h00000010;
    wb_en_in = 1'b1; wb_rd_sel_in = 6'd11; wb_data_in = 32'h00000011;
    tick();
    clear_inputs();
    rs1_sel = 5'd10; rs2_sel = 5'd11;
    #1;
    checks++;
    if (rs1_data !== 32'h10 || rs2_data !== 32'h11 || retire_count !== 32'd6) begin
      errs++; $display("FAIL dual_write: got %h/%h retire %0d want 10/11 6",
                       rs1_data, rs2_data, retire_count);
    end
    checks++;
    if (trace_wb_rd !== 5'd11 || trace_wb_data !== 32'h11) begin
      errs++; $display("FAIL dual_trace: got %0d/%h want 11/11", trace_wb_rd, trace_wb_data);
    end
  endtask

  task automatic test_back_to_back();
    ld_issue_in = 1'b1; ld_rd_sel_in = 6'd12;
    tick();
    ld_rd_sel_in = 6'd13; ld_valid_in = 1'b1; ld_data_in = 32'h0000000C;
    tick();
    clear_inputs();
    rs1_sel = 5'd12; rs2_sel = 5'd13;
    #1;
    checks++;
    if (rs1_data !== 32'hC || rs2_busy !== 1'b1 || ld_err !== 1'b0) begin
      errs++; $display("FAIL b2b_chain: got %h busy %b err %b want c 1 0",
                       rs1_data, rs2_busy, ld_err);
    end
    ld_valid_in = 1'b1; ld_data_in = 32'h0000000D;
    tick();
    clear_inputs();
    #1;
    checks++;
    if (rs2_data !== 32'hD || rs2_busy !== 1'b0 || retire_count !== 32'd8) begin
      errs++; $display("FAIL b2b_second: got %h busy %b retire %0d want d 0 8",
                       rs2_data, rs2_busy, retire_count);
    end
  endtask

  task automatic test_errors();
    // Issue to x0 must not start a load, so the following valid is a protocol error.
    ld_issue_in = 1'b1; ld_rd_sel_in = 6'd0;
    tick();
    clear_inputs();
    #1;
    checks++;
    if (ld_err !== 1'b0) begin
      errs++; $display("FAIL x0_issue_err: got %b want 0", ld_err);
    end
    ld_valid_in = 1'b1; ld_data_in = 32'h0000FFFF;
    tick();
    clear_inputs();
    tick();
    checks++;
    if (ld_err !== 1'b1 || retire_count !== 32'd8 || trace_wb_valid !== 1'b0) begin
      errs++; $display("FAIL idle_valid: got err %b retire %0d tv %b want 1 8 0",
                       ld_err, retire_count, trace_wb_valid);
    end
    ld_issue_in = 1'b1; ld_rd_sel_in = 6'd14;
    tick();
    ld_rd_sel_in = 6'd15;
    tick();
    clear_inputs();
    rs1_sel = 5'd14; rs2_sel = 5'd15;
    #1;
    checks++;
    if (rs1_busy !== 1'b1 || rs2_busy !== 1'b0 || ld_err !== 1'b1) begin
      errs++; $display("FAIL double_issue: got %b/%b err %b want 1/0 1",
                       rs1_busy, rs2_busy, ld_err);
    end
    ld_valid_in = 1'b1; ld_data_in = 32'h0000000E;
    tick();
    clear_inputs();
    #1;
    checks++;
    if (rs1_data !== 32'hE || rs2_data !== 32'd0 || retire_count !== 32'd9) begin
      errs++; $display("FAIL orig_kept: got %h/%h retire %0d want e/0 9",
                       rs1_data, rs2_data, retire_count);
    end
  endtask

  task automatic test_reset_pending();
    ld_issue_in = 1'b1; ld_rd_sel_in = 6'd16;
    tick();
    clear_inputs();
    rst_n = 1'b0;
    wb_en_in = 1'b1; wb_rd_sel_in = 6'd3; wb_data_in = 32'h33333333;
    tick();
    clear_inputs();
    rst_n = 1'b1;
    rs1_sel = 5'd5; rs2_sel = 5'd14;
    #1;
    checks++;
    if (rs1_data !== 32'd0 || rs2_data !== 32'd0 || retire_count !== 32'd0 || ld_err !== 1'b0) begin
      errs++; $display("FAIL rst_clear: got %h/%h retire %0d err %b want 0/0 0 0",
                       rs1_data, rs2_data, retire_count, ld_err);
    end
    checks++;
    if (trace_wb_valid !== 1'b0 || trace_wb_rd !== 5'd0 || trace_wb_data !== 32'd0) begin
      errs++; $display("FAIL rst_trace: got %b/%0d/%h want 0/0/0",
                       trace_wb_valid, trace_wb_rd, trace_wb_data);
    end
    rs1_sel = 5'd16; rs2_sel = 5'd3;
    #1;
    checks++;
    if (rs1_busy !== 1'b0 || rs2_data !== 32'd0) begin
      errs++; $display("FAIL rst_abandon: got busy %b x3 %h want 0 0", rs1_busy, rs2_data);
    end
    ld_valid_in = 1'b1; ld_data_in = 32'h00000077;
    #1;
    checks++;
    if (rs1_data !== 32'd0) begin
      errs++; $display("FAIL rst_no_bypass: got %h want 0", rs1_data);
    end
    tick();
    clear_inputs();
    #1;
    checks++;
    if (ld_err !== 1'b1 || rs1_data !== 32'd0 || retire_count !== 32'd0) begin
      errs++; $display("FAIL rst_late_valid: got err %b x16 %h retire %0d want 1 0 0",
                       ld_err, rs1_data, retire_count);
    end
  endtask

  initial begin
    errs   = 0;
    checks = 0;
    test_reset();
    test_alu_write();
    test_suppressed();
    test_load();
    test_collision();
    test_dual_write();
    test_back_to_back();
    test_errors();
    test_reset_pending();
    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end

endmodule

// File: doc/writeback_regfile.md
WRITEBACK_REGFILE -- requirements
Module: writeback_regfile

Interface
REQ-001 The block SHALL have parameter RETIRE_W, default 32, giving the width of the retire counter.
REQ-002 The block SHALL have input clk, 1 bit: the single clock; all state updates on its rising edge.
REQ-003 The block SHALL have input rst_n, 1 bit: synchronous, active-low reset, sampled on the rising edge of clk.
REQ-004 The block SHALL have input wb_en_in, 1 bit: ALU-path write request from the ALU pipeline register.
REQ-005 The block SHALL have input wb_rd_sel_in, 6 bits: ALU-path destination; bit 5 reserved, bits 4:0 register index.
REQ-006 The block SHALL have input wb_data_in, 32 bits: ALU-path write data.
REQ-007 The block SHALL have input ld_issue_in, 1 bit: a load has been issued to memory.
REQ-008 The block SHALL have input ld_rd_sel_in, 6 bits: destination of the issued load, same encoding as wb_rd_sel_in.
REQ-009 The block SHALL have input ld_valid_in, 1 bit: load data returned this cycle.
REQ-010 The block SHALL have input ld_data_in, 32 bits: returned load data.
REQ-011 The block SHALL have inputs rs1_sel and rs2_sel, 5 bits each: read-port register indices.
REQ-012 The block SHALL have outputs rs1_data and rs2_data, 32 bits each: combinational read data.
REQ-013 The block SHALL have outputs rs1_busy and rs2_busy, 1 bit each: the operand awaits an outstanding load.
REQ-014 The block SHALL have output ld_err, 1 bit: sticky protocol-error flag.
REQ-015 The block SHALL have output retire_count, RETIRE_W bits: count of architectural register writes.
REQ-016 The block SHALL have outputs trace_wb_valid (1 bit), trace_wb_rd (5 bits) and trace_wb_data (32 bits): registered write trace.

Function
REQ-017 The block SHALL hold 32 x 32-bit registers; x0 SHALL always read 0, and writes to x0 SHALL be discarded.
REQ-018 An ALU write SHALL occur at the clock edge when wb_en_in=1, wb_rd_sel_in[5]=0 and the index is nonzero.
REQ-019 A write with rd_sel bit 5 set SHALL be suppressed on either path, with no state, counter or trace change.
REQ-020 Load tracking SHALL be a two-state machine, IDLE and PENDING, recording the load destination index.
REQ-021 In IDLE, ld_issue_in=1 with a writable destination SHALL move the machine to PENDING and capture the index.
REQ-022 In IDLE, ld_issue_in=1 with x0 or bit 5 set as the destination SHALL leave the machine in IDLE.
REQ-023 In PENDING, ld_valid_in=1 SHALL write ld_data_in to the captured register and return the machine to IDLE.
REQ-024 In PENDING, ld_valid_in=1 together with ld_issue_in=1 SHALL complete the old load and accept the new one, leaving the machine in PENDING.
REQ-025 In PENDING, ld_issue_in=1 without ld_valid_in SHALL set ld_err, ignore the new load and keep the original.
REQ-026 In IDLE, ld_valid_in=1 SHALL set ld_err and write nothing.
REQ-027 When the ALU path and the load path target the same register in the same cycle, the ALU data SHALL be written, because it is younger; the load still completes and the machine returns to IDLE.
REQ-028 Writes to different registers on the two paths in the same cycle SHALL both occur.
REQ-029 A read port SHALL bypass same-cycle write data: the qualified ALU write first, then the load write, then the array.
REQ-030 rsN_busy SHALL be 1 only when the machine is PENDING, rsN_sel equals the captured index, and ld_valid_in=0.
REQ-031 retire_count SHALL increase by the number of architectural writes in a cycle (0, 1 or 2) and wrap modulo 2^RETIRE_W.
REQ-032 The trace outputs SHALL report one cycle after the write: the ALU write if present, otherwise the load write; trace_wb_valid SHALL be 0 when no write occurred.

Reset
REQ-033 While rst_n=0 at a clock edge, all 32 registers, the load state (to IDLE), ld_err, retire_count and all trace outputs SHALL be cleared to 0.
REQ-034 Reset SHALL take priority over all inputs in the same cycle.
REQ-035 A load that is PENDING when reset asserts SHALL be abandoned; a later ld_valid_in SHALL set ld_err.

Verification
REQ-036 ALU write x5=0xDEADBEEF, then read rs1_sel=5 -> rs1_data=0xDEADBEEF, retire_count=1, trace {1,5,0xDEADBEEF} one cycle later.
REQ-037 wb_en_in=1 with wb_rd_sel_in=0 or 6'h25 -> x0 and x5 unchanged, retire_count unchanged, trace_wb_valid=0.
REQ-038 Issue a load to x7, read x7 -> rs1_busy=1; on the ld_valid_in cycle with data 0x1234 -> busy=0 and rs1_data=0x1234 via bypass; next cycle the array holds 0x1234.
REQ-039 Load to x9 returns in the same cycle as an ALU write of x9=0xAA -> x9=0xAA, retire_count +2, machine returns to IDLE.
REQ-040 A second ld_issue_in while PENDING, or ld_valid_in while IDLE -> ld_err=1 and it stays 1 until reset.
REQ-041 rst_n=0 while PENDING, with registers nonzero -> all outputs and registers 0, machine IDLE, busy=0.
